// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control inputs and LUT programming from the sequencer side,
// PC / status outputs toward the instruction ROM and decode path.
interface fetch_unit_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             START;
    logic             BRANCH;
    logic [2:0]       TARGET_IDX;
    logic             HALT_REQ;
    logic             LUT_WE;
    logic [2:0]       LUT_ADDR;
    logic [PC_W-1:0]  LUT_DATA;
    logic [PC_W-1:0]  PC;
    logic             FETCH_VALID;
    logic             HALTED;
    logic [CNT_W-1:0] INST_COUNT;

    modport slave (
        input  START, BRANCH, TARGET_IDX, HALT_REQ, LUT_WE, LUT_ADDR, LUT_DATA,
        output PC, FETCH_VALID, HALTED, INST_COUNT
    );
    modport master (
        output START, BRANCH, TARGET_IDX, HALT_REQ, LUT_WE, LUT_ADDR, LUT_DATA,
        input  PC, FETCH_VALID, HALTED, INST_COUNT
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC and run/halt sequencing, 8-entry branch-target LUT,
// saturating issued-instruction counter.
module fetch_unit #(
    parameter int PC_W       = 8,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input logic          CLK,
    input logic          RESET,
    fetch_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    state_t                     r_state, w_state_nxt;
    logic [PC_W-1:0]            r_pc, w_pc_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic [7:0][PC_W-1:0]       r_lut;
    logic                       w_lut_wr;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_pc    <= PC_W'(START_ADDR);
            r_cnt   <= '0;
            r_lut   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_lut_wr) r_lut[bus.LUT_ADDR] <= bus.LUT_DATA;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_lut_wr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // LUT is only writable here so it is stable for the whole run
                w_lut_wr = bus.LUT_WE;
                if (bus.START) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = PC_W'(START_ADDR);
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
                if (bus.HALT_REQ)    w_state_nxt = S_HALTED;
                else if (bus.BRANCH) w_pc_nxt    = r_lut[bus.TARGET_IDX];
                else                 w_pc_nxt    = r_pc + 1'b1;
            end
            S_HALTED: begin
                if (bus.START) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = PC_W'(START_ADDR);
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.PC          = r_pc;
    assign bus.FETCH_VALID = (r_state == S_RUN);
    assign bus.HALTED      = (r_state == S_HALTED);
    assign bus.INST_COUNT  = r_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: main instance (CNT_W=16) plus a CNT_W=4
// instance for counter saturation.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.PC_W(8), .CNT_W(16)) b1 ();
    fetch_unit_if #(.PC_W(8), .CNT_W(4))  b2 ();

    fetch_unit #(.PC_W(8), .START_ADDR(0), .CNT_W(16)) u_dut (
        .CLK(clk), .RESET(rst_n), .bus(b1));
    fetch_unit #(.PC_W(8), .START_ADDR(0), .CNT_W(4)) u_sat (
        .CLK(clk), .RESET(rst2_n), .bus(b2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled at negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        b1.START = 0; b1.BRANCH = 0; b1.TARGET_IDX = 0; b1.HALT_REQ = 0;
        b1.LUT_WE = 0; b1.LUT_ADDR = 0; b1.LUT_DATA = 0;
        b2.START = 0; b2.BRANCH = 0; b2.TARGET_IDX = 0; b2.HALT_REQ = 0;
        b2.LUT_WE = 0; b2.LUT_ADDR = 0; b2.LUT_DATA = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", b1.PC, 0);
        chk("rst_fv", b1.FETCH_VALID, 0);
        chk("rst_halted", b1.HALTED, 0);
        chk("rst_cnt", b1.INST_COUNT, 0);
        rst_n = 1; rst2_n = 1;

        // basic run
        b1.START = 1; b2.START = 1;
        tick();
        b1.START = 0; b2.START = 0;
        chk("first_fv", b1.FETCH_VALID, 1);
        chk("first_pc", b1.PC, 0);
        ticks(4);
        chk("run4_pc", b1.PC, 4);
        chk("run4_cnt", b1.INST_COUNT, 4);
        chk("sat_cnt4", b2.INST_COUNT, 4);

        // LUT programming in IDLE; last write coincides with START
        do_reset();
        b1.LUT_WE = 1; b1.LUT_ADDR = 6; b1.LUT_DATA = 8'hFE;
        tick();
        chk("idle_wr_fv", b1.FETCH_VALID, 0);
        b1.LUT_ADDR = 5; b1.LUT_DATA = 8'h40; b1.START = 1;
        tick();
        b1.LUT_WE = 0; b1.START = 0;
        chk("wr_start_fv", b1.FETCH_VALID, 1);
        ticks(3);
        chk("pre_br_pc", b1.PC, 3);
        b1.BRANCH = 1; b1.TARGET_IDX = 5;
        tick();
        b1.BRANCH = 0;
        chk("br_pc", b1.PC, 8'h40);
        tick();
        chk("br_next_pc", b1.PC, 8'h41);
        chk("br_cnt", b1.INST_COUNT, 5);
        b1.START = 1;
        tick();
        b1.START = 0;
        chk("start_in_run", b1.PC, 8'h42);

        // halt, restart, run to 0x10, halt with simultaneous branch
        b1.HALT_REQ = 1;
        tick();
        b1.HALT_REQ = 0;
        chk("halt1", b1.HALTED, 1);
        b1.START = 1;
        tick();
        b1.START = 0;
        chk("restart_pc", b1.PC, 0);
        chk("restart_cnt", b1.INST_COUNT, 0);
        ticks(16);
        chk("pc10", b1.PC, 8'h10);
        b1.HALT_REQ = 1; b1.BRANCH = 1; b1.TARGET_IDX = 5;
        tick();
        b1.HALT_REQ = 0; b1.BRANCH = 0;
        chk("halt_halted", b1.HALTED, 1);
        chk("halt_fv", b1.FETCH_VALID, 0);
        chk("halt_pc", b1.PC, 8'h10);
        chk("halt_cnt", b1.INST_COUNT, 17);
        b1.BRANCH = 1; b1.LUT_WE = 1; b1.LUT_ADDR = 5; b1.LUT_DATA = 8'h99;
        ticks(2);
        b1.BRANCH = 0; b1.LUT_WE = 0;
        chk("hold_pc", b1.PC, 8'h10);
        chk("hold_cnt", b1.INST_COUNT, 17);
        b1.START = 1;
        tick();
        b1.START = 0;
        chk("rs_pc", b1.PC, 0);
        chk("rs_cnt", b1.INST_COUNT, 0);
        b1.BRANCH = 1; b1.TARGET_IDX = 5;
        tick();
        b1.BRANCH = 0;
        chk("lut_kept", b1.PC, 8'h40);

        // wrap
        b1.BRANCH = 1; b1.TARGET_IDX = 6;
        tick();
        b1.BRANCH = 0;
        chk("wrap_fe", b1.PC, 8'hFE);
        tick();
        chk("wrap_ff", b1.PC, 8'hFF);
        tick();
        chk("wrap_00", b1.PC, 8'h00);

        // LUT frozen in RUN
        b1.LUT_WE = 1; b1.LUT_ADDR = 2; b1.LUT_DATA = 8'h77;
        tick();
        b1.LUT_WE = 0;
        b1.BRANCH = 1; b1.TARGET_IDX = 2;
        tick();
        b1.BRANCH = 0;
        chk("lut_frozen", b1.PC, 8'h00);
        b1.START = 1;
        tick();
        b1.START = 0;
        chk("start_ign_pc", b1.PC, 8'h01);

        // async reset mid-cycle
        ticks(33);
        chk("pre_rst_pc", b1.PC, 8'h22);
        #2;
        rst_n = 0;
        #1;
        chk("arst_pc", b1.PC, 0);
        chk("arst_fv", b1.FETCH_VALID, 0);
        chk("arst_cnt", b1.INST_COUNT, 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("post_rst_idle", b1.FETCH_VALID, 0);
        chk("post_rst_halted", b1.HALTED, 0);
        b1.START = 1;
        tick();
        b1.START = 0;
        b1.BRANCH = 1; b1.TARGET_IDX = 5;
        tick();
        b1.BRANCH = 0;
        chk("lut_cleared", b1.PC, 0);

        chk("sat_cnt15", b2.INST_COUNT, 15);
        chk("sat_pc_wrap", b2.FETCH_VALID, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM and decode/control path.
- Owns the program counter and the run/halt sequencing.
- Owns an 8-entry branch-target lookup table that expands the 3-bit target field into a full PC address.
- Counts issued instructions for performance reporting at halt.

Parameters:
PC_W, 8, program counter / instruction address width
START_ADDR, 0, PC value loaded on reset and on every START
CNT_W, 16, width of the issued-instruction counter

Ports:
CLK  in  1  system clock; all state updates on rising edge
RESET  in  1  asynchronous, active-low reset
START  in  1  level; begin execution from START_ADDR (sampled in IDLE/HALTED)
BRANCH  in  1  taken-branch strobe (already qualified by ALU flag), sampled in RUN
TARGET_IDX  in  3  branch target index into LUT, from instruction bits [2:0]
HALT_REQ  in  1  halt decoded from current instruction, sampled in RUN
LUT_WE  in  1  branch-target LUT write enable (honoured in IDLE only)
LUT_ADDR  in  3  LUT write index
LUT_DATA  in  PC_W  LUT write data
PC  out  PC_W  current instruction address to ROM
FETCH_VALID  out  1  high when PC addresses an instruction being issued this cycle
HALTED  out  1  high in HALTED state
INST_COUNT  out  CNT_W  instructions issued since last START

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; PC=START_ADDR; INST_COUNT=0; FETCH_VALID=0; HALTED=0; all LUT entries=0.
  - Takes effect immediately, including mid-RUN; the in-flight instruction is discarded.
- FSM states: IDLE, RUN, HALTED. Outputs are Moore: FETCH_VALID = (state==RUN), HALTED = (state==HALTED).
- IDLE:
  - LUT_WE=1 writes LUT[LUT_ADDR] <= LUT_DATA at the edge.
  - START=1 -> RUN next cycle; PC <= START_ADDR; INST_COUNT <= 0.
  - If LUT_WE and START are both high, the write completes and the transition also occurs.
- RUN, one instruction per cycle; next-PC priority:
  1. HALT_REQ=1 -> HALTED; PC holds (remains the address of the halt instruction); BRANCH ignored.
  2. BRANCH=1 -> PC <= LUT[TARGET_IDX].
  3. Otherwise PC <= PC+1, mod 2^PC_W (all-ones wraps to 0, no flag).
- INST_COUNT:
  - Increments by 1 on every RUN-state edge, including the edge that leaves RUN on HALT_REQ.
  - Saturates at 2^CNT_W-1; no wrap.
- Ignored inputs:
  - In RUN: START and LUT_WE are ignored; LUT contents are frozen.
  - In HALTED and IDLE: BRANCH and HALT_REQ are ignored.
- HALTED:
  - PC and INST_COUNT hold; LUT_WE ignored.
  - START=1 -> RUN; PC <= START_ADDR; INST_COUNT <= 0. Restarts without reset, and the LUT is retained.
- Latency:
  - A PC change is visible one cycle after the edge that samples BRANCH or HALT_REQ.
  - The first fetch is issued in the cycle after START is sampled.
  - No bubbles: a taken branch costs zero cycles at this stage.

Test Plan:
- Reset, then START high for 1 cycle -> FETCH_VALID=1 next cycle with PC=0; after 4 more cycles PC=4 and INST_COUNT=4.
- In IDLE, write LUT[5]=0x40, START; at PC=3 assert BRANCH with TARGET_IDX=5 -> next cycle PC=0x40; following cycle PC=0x41.
- At PC=0x10 assert HALT_REQ and BRANCH together (TARGET_IDX=5) -> HALTED=1, FETCH_VALID=0, PC stays 0x10, INST_COUNT=17; then START -> PC=0 and INST_COUNT=0, with LUT[5] still 0x40.
- Run from PC=0xFE with no branch -> PC sequence 0xFE, 0xFF, 0x00; set CNT_W=4 and run 20 cycles -> INST_COUNT saturates at 15.
- Assert LUT_WE (LUT[2]=0x77) while in RUN, then branch with TARGET_IDX=2 -> PC=0x00 (entry unchanged); assert START in RUN -> PC continues incrementing.
- Drop RESET asynchronously mid-cycle in RUN at PC=0x22 -> PC=0, FETCH_VALID=0, INST_COUNT=0 before the next edge; LUT cleared; state=IDLE after release.
